// File: rtl/operand_bypass_mux_pkg.sv
// Shared definitions for the ID/EX operand-select stage: default widths,
// the hard-wired zero register and the hazard FSM state encodings.
package operand_bypass_mux_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int NUM_FWD_DEF = 2;
    localparam int CNT_W_DEF   = 16;

    // $zero: reads as 0 and is never a forwarding target
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Hazard FSM encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HAZ  = 1'b1;

    // Width of a stage index; at least one bit even with a single stage
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_bypass_mux_fwd_match_prio.sv
// Forwarding-match priority encoder: finds the youngest in-flight writer
// whose destination equals the source register ($zero never matches).
module fwd_match_prio
    import operand_bypass_mux_pkg::*;
#(
    parameter  int NUM_FWD = NUM_FWD_DEF,
    parameter  int REG_AW  = REG_AW_DEF,
    localparam int IDX_W   = idx_w(NUM_FWD)
) (
    input  logic [REG_AW-1:0]         rs_addr,
    input  logic [NUM_FWD-1:0]        fwd_wen,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    output logic                      hit,
    output logic [NUM_FWD-1:0]        winner_oh,
    output logic [IDX_W-1:0]          winner_idx
);

    // Scan oldest to youngest so the lowest matching index is written last and wins
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        hit        = 1'b0;
        winner_oh  = '0;
        winner_idx = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_wen[k] &&
                (fwd_addr[k*REG_AW +: REG_AW] == rs_addr) &&
                (rs_addr != REG_AW'(ZERO_REG))) begin
                hit          = 1'b1;
                winner_oh    = '0;
                winner_oh[k] = 1'b1;
                winner_idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/operand_bypass_mux.sv
// ID->EX operand select stage: chooses register-file or forwarded data,
// stalls on load-use hazards, registers the operand for EX and counts
// hazard stall cycles.
module operand_bypass_mux
    import operand_bypass_mux_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int REG_AW  = REG_AW_DEF,
    parameter  int NUM_FWD = NUM_FWD_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_AW-1:0]         rs_addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]        fwd_wen,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_is_load,
    input  logic                      stall_in,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      hazard_stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int IDX_W = idx_w(NUM_FWD);

    logic                 hit;
    logic [NUM_FWD-1:0]   winner_oh;
    logic [IDX_W-1:0]     winner_idx;
    logic [DATA_W-1:0]    sel_data;
    logic [SEL_W-1:0]     sel_src;
    logic                 sel_is_load;
    logic                 hazard;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_sel_q,   out_sel_d;
    logic [0:0]           state_q,     state_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

    fwd_match_prio #(
        .NUM_FWD (NUM_FWD),
        .REG_AW  (REG_AW)
    ) u_match (
        .rs_addr    (rs_addr),
        .fwd_wen    (fwd_wen),
        .fwd_addr   (fwd_addr),
        .hit        (hit),
        .winner_oh  (winner_oh),
        .winner_idx (winner_idx)
    );

    // Operand mux: $zero forces 0, else winning stage, else register file
    always_comb begin
        sel_data    = rf_data;
        sel_src     = '0;
        sel_is_load = 1'b0;
        if (rs_addr == REG_AW'(ZERO_REG)) begin
            sel_data = '0;
        end else if (hit) begin
            sel_src = SEL_W'(winner_idx) + SEL_W'(1);
            for (int k = 0; k < NUM_FWD; k++) begin
                if (winner_oh[k]) begin
                    sel_data    = fwd_data[k*DATA_W +: DATA_W];
                    sel_is_load = fwd_is_load[k];
                end
            end
        end
    end

    // A winning load still in flight blocks acceptance
    assign hazard       = in_valid & sel_is_load;
    assign hazard_stall = hazard;
    assign in_ready     = in_valid & ~hazard & ~stall_in & ~flush;

    // Output register next state: flush > stall_in > accept > bubble
    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (stall_in) begin
            out_valid_d = out_valid_q;
        end else if (in_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = sel_src;
        end
    end

    // Hazard FSM next state; tracks stall episodes, does not gate the datapath
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hazard && !flush) state_d = ST_HAZ;
            ST_HAZ:  if (!hazard || flush) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating hazard-cycle counter next state
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule
